// File: rtl/lambdagen_s2p_pkg.sv
// Shared rasteriser definitions for the lambda setup stage: derived widths,
// cull-mode encodings and the cull decision.
package lambdagen_s2p_pkg;

    typedef enum logic [1:0] {
        CULL_NONE     = 2'd0,
        CULL_ZERO     = 2'd1,
        CULL_ZERO_NEG = 2'd2,
        CULL_RSVD     = 2'd3
    } cull_mode_e;

    function automatic int pxw(input int xw);
        return 2 * xw + 3;
    endfunction

    function automatic int pyw(input int yw);
        return 2 * yw + 3;
    endfunction

    function automatic int aw(input int xw, input int yw);
        return xw + yw + 3;
    endfunction

    function automatic int sw(input int xw, input int yw);
        return xw + yw + 4;
    endfunction

    // The reserved encoding behaves like CULL_NONE.
    function automatic logic cull_hit(input cull_mode_e m, input logic degen, input logic back);
        case (m)
            CULL_ZERO:     return degen;
            CULL_ZERO_NEG: return degen | back;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lambdagen_s2p_if.sv
// Triangle handshake bus: upstream vertex/edge data in, setup products out.
interface lambdagen_s2p_if
    import lambdagen_s2p_pkg::*;
#(
    parameter int XWIDTH  = 9,
    parameter int YWIDTH  = 8,
    parameter int ZWIDTH  = 16,
    parameter int IDWIDTH = 16
);
    localparam int PXW = pxw(XWIDTH);
    localparam int PYW = pyw(YWIDTH);
    localparam int AW  = aw(XWIDTH, YWIDTH);
    localparam int SW  = sw(XWIDTH, YWIDTH);

    logic                      in_valid;
    logic                      in_ready;
    logic signed [XWIDTH:0]    dl1x_i, dl2x_i;
    logic signed [YWIDTH:0]    dl1y_i, dl2y_i;
    logic [XWIDTH-1:0]         x1_i, x2_i;
    logic [YWIDTH-1:0]         y1_i, y2_i;
    logic signed [ZWIDTH-1:0]  z1_i, z2_i, z3_i;
    logic [IDWIDTH-1:0]        tid_i;

    logic                      out_valid;
    logic                      out_ready;
    logic signed [PYW-1:0]     x12y1_o, x23y2_o;
    logic signed [PXW-1:0]     y12x1_o, y23x2_o;
    logic signed [AW-1:0]      a0_o, a1_o;
    logic signed [SW-1:0]      area_o;
    logic                      degen_o, back_o;
    logic signed [XWIDTH:0]    dl1x_o, dl2x_o;
    logic signed [YWIDTH:0]    dl1y_o, dl2y_o;
    logic signed [ZWIDTH-1:0]  z1_o, z2_o, z3_o;
    logic [IDWIDTH-1:0]        tid_o;

    modport master (
        output in_valid, dl1x_i, dl2x_i, dl1y_i, dl2y_i, x1_i, x2_i, y1_i, y2_i,
               z1_i, z2_i, z3_i, tid_i, out_ready,
        input  in_ready, out_valid, x12y1_o, x23y2_o, y12x1_o, y23x2_o, a0_o, a1_o,
               area_o, degen_o, back_o, dl1x_o, dl2x_o, dl1y_o, dl2y_o,
               z1_o, z2_o, z3_o, tid_o
    );

    modport slave (
        input  in_valid, dl1x_i, dl2x_i, dl1y_i, dl2y_i, x1_i, x2_i, y1_i, y2_i,
               z1_i, z2_i, z3_i, tid_i, out_ready,
        output in_ready, out_valid, x12y1_o, x23y2_o, y12x1_o, y23x2_o, a0_o, a1_o,
               area_o, degen_o, back_o, dl1x_o, dl2x_o, dl1y_o, dl2y_o,
               z1_o, z2_o, z3_o, tid_o
    );

endinterface

// File: rtl/lambdagen_pipe_stage.sv
// One elastic register slice: captures its input whenever the controller says
// the slot is free (empty or draining this cycle).
module lambdagen_pipe_stage #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         vld_i,
    input  logic [W-1:0] data_i,
    output logic         vld_o,
    output logic [W-1:0] data_o
);
    logic         vld_q, vld_d;
    logic [W-1:0] data_q, data_d;

    // Data only moves on a real transfer so a bubble leaves the old payload in place.
    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (load) begin
            vld_d = vld_i;
            if (vld_i) data_d = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/lambdagen_s2p.sv
// Lambda setup: edge/vertex cross products, signed area and back/zero-area
// culling through a LAT-deep elastic pipeline.
module lambdagen_s2p
    import lambdagen_s2p_pkg::*;
#(
    parameter int XWIDTH  = 9,
    parameter int YWIDTH  = 8,
    parameter int ZWIDTH  = 16,
    parameter int IDWIDTH = 16,
    parameter int LAT     = 2
) (
    input  logic          clk,
    input  logic          rst,
    lambdagen_s2p_if.slave bus,
    input  logic [1:0]    cull_mode,
    input  logic          clr_stats,
    output logic [15:0]   cull_cnt
);
    localparam int PXW = pxw(XWIDTH);
    localparam int PYW = pyw(YWIDTH);
    localparam int AW  = aw(XWIDTH, YWIDTH);
    localparam int SW  = sw(XWIDTH, YWIDTH);
    // Carried payload: {cull_mode, dl*, z*, tid, products, a0, a1}; a0/a1 sit at the bottom.
    localparam int BW  = 2 + 2 * (XWIDTH + 1) + 2 * (YWIDTH + 1) + 3 * ZWIDTH + IDWIDTH
                         + 2 * PYW + 2 * PXW + 2 * AW;
    localparam int VW  = BW + SW + 2;
    localparam int NM  = (LAT > 1) ? LAT - 1 : 1;

    function automatic logic [VW-1:0] with_area(input logic [BW-1:0] b);
        logic signed [SW-1:0] s;
        s = $signed({b[2*AW-1], b[2*AW-1:AW]}) + $signed({b[AW-1], b[AW-1:0]});
        return {b, s, (s == '0), s[SW-1]};
    endfunction

    logic signed [PYW-1:0] dl1y_e, dl2y_e, y1_e, y2_e, x12y1_c, x23y2_c;
    logic signed [PXW-1:0] dl1x_e, dl2x_e, x1_e, x2_e, y12x1_c, y23x2_c;
    logic signed [AW-1:0]  a_dl1y, a_dl2x, a_dl1x, a_dl2y, a0_c, a1_c;
    logic [BW-1:0]         base_c;

    // Operands widened to the full product width so every product is exact.
    always_comb begin
        dl1y_e  = {{(PYW-YWIDTH-1){bus.dl1y_i[YWIDTH]}}, bus.dl1y_i};
        dl2y_e  = {{(PYW-YWIDTH-1){bus.dl2y_i[YWIDTH]}}, bus.dl2y_i};
        y1_e    = {{(PYW-YWIDTH){1'b0}}, bus.y1_i};
        y2_e    = {{(PYW-YWIDTH){1'b0}}, bus.y2_i};
        dl1x_e  = {{(PXW-XWIDTH-1){bus.dl1x_i[XWIDTH]}}, bus.dl1x_i};
        dl2x_e  = {{(PXW-XWIDTH-1){bus.dl2x_i[XWIDTH]}}, bus.dl2x_i};
        x1_e    = {{(PXW-XWIDTH){1'b0}}, bus.x1_i};
        x2_e    = {{(PXW-XWIDTH){1'b0}}, bus.x2_i};
        a_dl1y  = {{(AW-YWIDTH-1){bus.dl1y_i[YWIDTH]}}, bus.dl1y_i};
        a_dl2y  = {{(AW-YWIDTH-1){bus.dl2y_i[YWIDTH]}}, bus.dl2y_i};
        a_dl1x  = {{(AW-XWIDTH-1){bus.dl1x_i[XWIDTH]}}, bus.dl1x_i};
        a_dl2x  = {{(AW-XWIDTH-1){bus.dl2x_i[XWIDTH]}}, bus.dl2x_i};
        x12y1_c = -(dl1y_e * y1_e);
        x23y2_c = -(dl2y_e * y2_e);
        y12x1_c = -(dl1x_e * x1_e);
        y23x2_c = -(dl2x_e * x2_e);
        a0_c    = a_dl1y * a_dl2x;
        a1_c    = -(a_dl1x * a_dl2y);
        base_c  = {cull_mode, bus.dl1x_i, bus.dl2x_i, bus.dl1y_i, bus.dl2y_i,
                   bus.z1_i, bus.z2_i, bus.z3_i, bus.tid_i,
                   x12y1_c, x23y2_c, y12x1_c, y23x2_c, a0_c, a1_c};
    end

    logic [LAT-1:0] vld, ld, vin;
    logic [BW-1:0]  mid_in [NM];
    logic [BW-1:0]  mid_q  [NM];
    logic [BW-1:0]  last_base;
    logic [VW-1:0]  last_in;
    logic [VW-3:0]  last_q;
    logic           hit;

    // A slot may load when empty or when everything ahead of it drains this cycle.
    always_comb begin
        logic ok;
        ok = bus.out_ready;
        for (int i = LAT - 1; i >= 0; i--) begin
            ok    = ~vld[i] | ok;
            ld[i] = ok;
        end
    end

    assign bus.in_ready = rst & ld[0];

    generate
        if (LAT == 1) begin : g_direct
            assign vin[0]    = bus.in_valid;
            assign last_base = base_c;
        end else begin : g_mid
            for (genvar i = 0; i < LAT - 1; i++) begin : g_stage
                if (i == 0) begin : g_head
                    assign mid_in[i] = base_c;
                    assign vin[i]    = bus.in_valid;
                end else begin : g_body
                    assign mid_in[i] = mid_q[i-1];
                    assign vin[i]    = vld[i-1];
                end
                lambdagen_pipe_stage #(.W(BW)) u_stage (
                    .clk   (clk),
                    .rst   (rst),
                    .load  (ld[i]),
                    .vld_i (vin[i]),
                    .data_i(mid_in[i]),
                    .vld_o (vld[i]),
                    .data_o(mid_q[i])
                );
            end
            assign vin[LAT-1] = vld[LAT-2];
            assign last_base  = mid_q[LAT-2];
        end
    endgenerate

    // Final slice: area is formed here and the carried cull mode decides whether it lands.
    assign last_in = with_area(last_base);
    assign hit     = cull_hit(cull_mode_e'(last_in[VW-1 -: 2]), last_in[1], last_in[0]);

    lambdagen_pipe_stage #(.W(VW - 2)) u_last (
        .clk   (clk),
        .rst   (rst),
        .load  (ld[LAT-1]),
        .vld_i (vin[LAT-1] & ~hit),
        .data_i(last_in[VW-3:0]),
        .vld_o (vld[LAT-1]),
        .data_o(last_q)
    );

    assign bus.out_valid = vld[LAT-1];
    assign {bus.dl1x_o, bus.dl2x_o, bus.dl1y_o, bus.dl2y_o, bus.z1_o, bus.z2_o, bus.z3_o,
            bus.tid_o, bus.x12y1_o, bus.x23y2_o, bus.y12x1_o, bus.y23x2_o,
            bus.a0_o, bus.a1_o, bus.area_o, bus.degen_o, bus.back_o} = last_q;

    logic [15:0] cull_cnt_q, cull_cnt_d;
    logic        cull_ev;

    assign cull_ev = vin[LAT-1] & ld[LAT-1] & hit;

    always_comb begin
        cull_cnt_d = cull_cnt_q;
        if (clr_stats)
            cull_cnt_d = {15'd0, cull_ev};
        else if (cull_ev && cull_cnt_q != 16'hFFFF)
            cull_cnt_d = cull_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cull_cnt_q <= '0;
        else      cull_cnt_q <= cull_cnt_d;
    end

    assign cull_cnt = cull_cnt_q;

endmodule

// File: doc/lambdagen_s2p.md
LAMBDAGEN_S2P -- requirements
Module: lambdagen_s2p

Interface
REQ-001 SHALL have parameters: XWIDTH, default 9, screen-x coordinate bits; YWIDTH, default 8, screen-y bits; ZWIDTH, default 16, depth bits; IDWIDTH, default 16, triangle-ID bits; LAT, default 2, register stages from input to output, legal range 1..4.
REQ-002 SHALL derive PXW=2*XWIDTH+3, PYW=2*YWIDTH+3, AW=XWIDTH+YWIDTH+3, SW=AW+1.
REQ-003 SHALL have the following ports, one per line as name, direction, width, meaning:
clk  in  1  single clock, rising edge;
rst  in  1  reset, asynchronous, active-low;
in_valid  in  1  input triangle present;
in_ready  out  1  block accepts the input this cycle;
dl1x_i, dl2x_i  in  XWIDTH+1 signed  edge x deltas;
dl1y_i, dl2y_i  in  YWIDTH+1 signed  edge y deltas;
x1_i, x2_i  in  XWIDTH unsigned  vertex x;
y1_i, y2_i  in  YWIDTH unsigned  vertex y;
z1_i, z2_i, z3_i  in  ZWIDTH signed  vertex depth;
tid_i  in  IDWIDTH  triangle ID;
cull_mode  in  2  0 none, 1 drop zero-area, 2 drop zero- and negative-area, 3 reserved (treated as 0);
clr_stats  in  1  synchronous clear of cull_cnt;
out_valid  out  1  output triangle present;
out_ready  in  1  downstream accepts;
x12y1_o, x23y2_o  out  PYW signed;
y12x1_o, y23x2_o  out  PXW signed;
a0_o, a1_o  out  AW signed;
area_o  out  SW signed  a0+a1;
degen_o  out  1  area_o==0;
back_o  out  1  area_o<0;
dl*, z*, tid outputs  out  widths as the inputs  pass-through;
cull_cnt  out  16  culled-triangle count.

Function
REQ-004 SHALL compute x12y1=-(dl1y*{0,y1}), x23y2=-(dl2y*{0,y2}), y12x1=-(dl1x*{0,x1}), y23x2=-(dl2x*{0,x2}), a0=dl1y*dl2x, a1=-(dl1x*dl2y), all exact in signed arithmetic with no truncation.
REQ-005 SHALL form area, degen and back combinationally from the a0/a1 stage values and register them with them.
REQ-006 SHALL accept an input on a cycle with in_valid and in_ready both high.
REQ-007 SHALL present an accepted, non-culled triangle with out_valid high exactly LAT cycles after acceptance when out_ready stays high.
REQ-008 SHALL sustain one triangle per cycle under continuous in_valid and out_ready.
REQ-009 SHALL implement a per-stage elastic pipeline: a stage loads when it is empty or its contents advance in the same cycle.
REQ-010 SHALL drive in_ready = !v[0] || advance[0], with no combinational path from in_valid to in_ready.
REQ-011 SHALL hold every output stable while out_valid is high and out_ready is low.
REQ-012 SHALL evaluate culling when a triangle enters the last stage, using the cull_mode value sampled at acceptance and carried with the triangle.
REQ-013 SHALL clear the valid bit of a culled triangle, so it never raises out_valid and frees its slot.
REQ-014 SHALL increment cull_cnt once per culled triangle, saturating at 0xFFFF.
REQ-015 SHALL clear cull_cnt when clr_stats is high; if a cull happens in the same cycle, cull_cnt SHALL become 1.
REQ-016 SHALL not reorder triangles; the tid order at the output matches the accepted order minus culled triangles.

Reset
REQ-017 SHALL, while rst is low, clear all valid bits, out_valid, and cull_cnt, and drive in_ready low.
REQ-018 SHALL clear all data registers and outputs to zero during reset.
REQ-019 SHALL discard in-flight triangles when reset is asserted mid-stream.
REQ-020 SHALL raise in_ready in the first cycle after rst deasserts.

Structure
REQ-021 SHALL take the width derivations (PXW, PYW, AW, SW) and the cull_mode encodings from the shared rasteriser package.
REQ-022 SHALL place one natural sub-module, lambdagen_pipe_stage, as a single elastic register slice instantiated LAT times.

Verification
REQ-023 Scenario: dl1x=3, dl1y=-2, dl2x=5, dl2y=4, x1=10, y1=7, x2=20, y2=9, LAT=2 -> after 2 cycles x12y1=14, x23y2=-36, y12x1=-30, y23x2=-100, a0=-10, a1=-12, area=-22, back=1.
REQ-024 Scenario: same triangle with cull_mode=2 -> no out_valid, cull_cnt=1; with cull_mode=1 -> output delivered.
REQ-025 Scenario: dl1x=2, dl1y=2, dl2x=4, dl2y=4, cull_mode=1 -> a0=8, a1=-8, area=0, triangle dropped.
REQ-026 Scenario: 8 back-to-back triangles with out_ready low for cycles 3-6 -> no loss or duplication, outputs stable while stalled, tid order preserved, in_ready low once full.
REQ-027 Scenario: rst pulsed low with 2 triangles in flight -> out_valid=0 and cull_cnt=0 next cycle, in_ready=1 after release.
REQ-028 Scenario: extreme values dl1x=-512, x1=511 -> y12x1=261632, exact with no wrap.
